// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping core: state encoding,
// counter limits and output field widths.
package stopwatch_pkg;

    // Control FSM state encoding
    localparam logic [1:0] STOP  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    // Output field widths
    localparam int unsigned MSEC_W = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    // Counter maxima (wrap points)
    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// 1/100 s tick generator. tick_cnt advances only while enabled, holds
// otherwise so a stop/start keeps sub-tick time, and loads 0 on clear.
module stopwatch_tick_gen #(
    parameter int unsigned TICK_COUNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int unsigned CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;

    // Next count and the wrap-cycle tick
    always_comb begin
        tick_o     = enable_i && (tick_cnt_q == LAST);
        tick_cnt_d = tick_cnt_q;
        if (clear_i) begin
            tick_cnt_d = '0;
        end else if (enable_i) begin
            tick_cnt_d = tick_o ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Tick counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch timekeeping core: run/stop/clear FSM, tick-gated cascaded
// counters (0-99 / 0-59 / 0-59 / 0-23) and optional lap hold.
// Build option: define STOPWATCH_LAP_EN to enable the lap-hold snapshot.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_COUNT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_run,
    input  logic              btn_clear,
    input  logic              btn_lap,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              run_active,
    output logic              lap_active
);
    logic [1:0]        state_q, state_d;
    logic              count_en, clear_now, tick;
    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [MIN_W-1:0]  min_q,  min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;

    // Control FSM next state; clear has priority over run in STOP
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP: begin
                if (btn_clear)    state_d = CLEAR;
                else if (btn_run) state_d = RUN;
            end
            RUN:     if (btn_run) state_d = STOP;
            CLEAR:   state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= STOP;
        else     state_q <= state_d;
    end

    // Counting only on edges that stay in RUN, so the stop edge never ticks;
    // clearing acts on the edge entering CLEAR so outputs read 0 from there
    assign count_en   = (state_q == RUN) && (state_d == RUN);
    assign clear_now  = (state_d == CLEAR);
    assign run_active = (state_q == RUN);

    stopwatch_tick_gen #(
        .TICK_COUNT(TICK_COUNT)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .enable_i(count_en),
        .clear_i (clear_now),
        .tick_o  (tick)
    );

    // Single-edge carry cascade msec -> sec -> min -> hour
    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (clear_now) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick) begin
            if (msec_q == MSEC_MAX) begin
                msec_d = '0;
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_MAX) begin
                        min_d  = '0;
                        hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                    end else begin
                        min_d = min_q + 1'b1;
                    end
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                msec_d = msec_q + 1'b1;
            end
        end
    end

    // Live time counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic              hold_q, hold_d;
    logic [MSEC_W-1:0] lap_msec_q;
    logic [SEC_W-1:0]  lap_sec_q;
    logic [MIN_W-1:0]  lap_min_q;
    logic [HOUR_W-1:0] lap_hour_q;

    // Hold toggles in RUN, releases in STOP or when clearing
    always_comb begin
        hold_d = hold_q;
        if (clear_now)                             hold_d = 1'b0;
        else if (btn_lap && state_q == RUN)        hold_d = ~hold_q;
        else if (btn_lap && state_q == STOP)       hold_d = 1'b0;
    end

    // Hold flag and snapshot of the live value on entering hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= 1'b0;
            lap_msec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            lap_hour_q <= '0;
        end else begin
            hold_q <= hold_d;
            if (hold_d && !hold_q) begin
                lap_msec_q <= msec_d;
                lap_sec_q  <= sec_d;
                lap_min_q  <= min_d;
                lap_hour_q <= hour_d;
            end
        end
    end

    assign lap_active = hold_q;
    assign msec = hold_q ? lap_msec_q : msec_q;
    assign sec  = hold_q ? lap_sec_q  : sec_q;
    assign min  = hold_q ? lap_min_q  : min_q;
    assign hour = hold_q ? lap_hour_q : hour_q;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
    assign lap_active = 1'b0;
    assign msec = msec_q;
    assign sec  = sec_q;
    assign min  = min_q;
    assign hour = hour_q;
`endif

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed self-checking bench for stopwatch_datapath with TICK_COUNT = 4.
// Inputs change 1 ns after posedge; outputs are checked there too.
module tb_stopwatch_datapath;
    localparam int unsigned TC = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       run_active, lap_active;

    int unsigned errors = 0;
    int unsigned checks = 0;

    stopwatch_datapath #(.TICK_COUNT(TC)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .msec      (msec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .run_active(run_active),
        .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic r, input logic c, input logic l);
        btn_run = r; btn_clear = c; btn_lap = l;
        step(1);
        btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int unsigned h, input int unsigned m,
                            input int unsigned s, input int unsigned ms);
        chk({tag, ".hour"}, hour, h);
        chk({tag, ".min"},  min,  m);
        chk({tag, ".sec"},  sec,  s);
        chk({tag, ".msec"}, msec, ms);
    endtask

    initial begin
        // Reset state
        #2;
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.run_active", run_active, 0);
        chk("reset.lap_active", lap_active, 0);
        step(2);
        rst = 1'b0;

        // Clear from STOP: one CLEAR cycle, outputs stay 0
        pulse(0, 1, 0);
        chk("clr.run_active", run_active, 0);
        chk_time("clr", 0, 0, 0, 0);
        step(1);
        chk("clr_after.run_active", run_active, 0);

        // Run 400 cycles -> 1.00 s
        pulse(1, 0, 0);
        chk("run.run_active", run_active, 1);
        step(399);
        chk_time("run399", 0, 0, 0, 99);
        step(1);
        chk_time("run400", 0, 0, 1, 0);
        chk("run400.run_active", run_active, 1);

        // Stop with tick_cnt = 2, hold, restart: 2 cycles to next tick
        step(2);
        pulse(1, 0, 0);
        chk("stop.run_active", run_active, 0);
        step(120);
        chk_time("frozen", 0, 0, 1, 0);
        pulse(1, 0, 0);
        chk("restart.run_active", run_active, 1);
        step(1);
        chk("restart+1.msec", msec, 0);
        step(1);
        chk("restart+2.msec", msec, 1);

        // Full-cascade wrap from 23:59:59.98
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        step(1);
        pulse(1, 0, 0);
        force dut.msec_q = 7'd98;
        force dut.sec_q  = 6'd59;
        force dut.min_q  = 6'd59;
        force dut.hour_q = 5'd23;
        #1;
        release dut.msec_q;
        release dut.sec_q;
        release dut.min_q;
        release dut.hour_q;
        step(3);
        chk_time("pre_wrap", 23, 59, 59, 98);
        step(1);
        chk_time("max", 23, 59, 59, 99);
        step(3);
        chk("max_hold.msec", msec, 99);
        step(1);
        chk_time("wrap", 0, 0, 0, 0);

        // btn_clear ignored in RUN
        pulse(0, 1, 0);
        chk("run_clr.run_active", run_active, 1);
        step(3);
        chk("run_clr.msec", msec, 1);
        step(2);

        // Stop (tick_cnt = 2), then clear+run together: clear wins
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        chk("clrrun.run_active", run_active, 0);
        chk("clrrun.msec", msec, 0);
        step(1);
        chk("clrrun_after.run_active", run_active, 0);
        step(8);
        chk("clrrun_idle.run_active", run_active, 0);
        chk("clrrun_idle.msec", msec, 0);
        pulse(1, 0, 0);
        step(3);
        chk("cnt_cleared+3.msec", msec, 0);
        step(1);
        chk("cnt_cleared+4.msec", msec, 1);

        // Lap hold (no effect without the lap build)
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        step(1);
        pulse(1, 0, 0);
        step(40);
        chk("lap_pre.msec", msec, 10);
        pulse(0, 0, 1);
        chk("lap_on.lap_active", lap_active, LAP);
        chk("lap_on.msec", msec, 10);
        step(8);
        chk("lap_hold.msec", msec, LAP ? 10 : 12);
        chk("lap_hold.lap_active", lap_active, LAP);
        pulse(1, 0, 0);
        chk("lap_stop.run_active", run_active, 0);
        chk("lap_stop.msec", msec, LAP ? 10 : 12);
        pulse(0, 0, 1);
        chk("lap_rel.lap_active", lap_active, 0);
        chk("lap_rel.msec", msec, 12);

        // Asynchronous reset mid-count with hold active
        pulse(1, 0, 0);
        step(5);
        pulse(0, 0, 1);
        step(6);
        chk("pre_rst.lap_active", lap_active, LAP);
        #3 rst = 1'b1;
        #1;
        chk_time("async_rst", 0, 0, 0, 0);
        chk("async_rst.run_active", run_active, 0);
        chk("async_rst.lap_active", lap_active, 0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("post_rst.run_active", run_active, 0);
        chk("post_rst.msec", msec, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
